pattern_scan_ctrl: RTL and testbench

- Hardware sequencer for program 3 (5-bit pattern search). Takes over the data-memory port and reads the pattern byte and the 32 message bytes.
- Computes three counts and writes them back to the result locations: in-byte matches, bytes with at least one match, and matches across the whole bit string.
- Sits beside the core on the data-memory port. Handshakes with the top level through start/ack.

---
 rtl/pattern_scan_ctrl_if.sv | 33 +++
 rtl/pattern_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_ctrl_if.sv
// Start/ack handshake and data-memory port of the
// pattern scan sequencer.
interface pattern_scan_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic          ack;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem_wdata;
  logic          mem_we;

  modport master (
    input  start,
    input  mem_rdata,
    output ack,
    output busy,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    output start,
    output mem_rdata,
    input  ack,
    input  busy,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Program-3 sequencer: counts 5-bit pattern hits in a
// byte message and writes the three counts to memory.
module pattern_scan_ctrl #(
  parameter int NUM_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33,
  parameter int AW        = 8
) (
  input logic               clk,
  input logic               reset,
  pattern_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LDPAT, SCAN,
    WR_CTB, WR_CTO, WR_CTS,
    DONE
  } state_t;

  localparam logic [AW-1:0] PAT_A = AW'(PAT_ADDR);
  localparam logic [AW-1:0] RES_A = AW'(RES_ADDR);
  localparam logic [AW-1:0] LAST  = AW'(NUM_BYTES - 1);

  state_t        state, nxt;
  logic [AW-1:0] idx;
  logic [4:0]    pat;
  logic [7:0]    prev;
  logic [7:0]    ctb, cto, cts;
  logic [7:0]    cur;
  logic [11:0]   win;
  logic [2:0]    in_cnt;
  logic [3:0]    cs_cnt;

  assign cur = bus.mem_rdata;
  assign win = {prev[3:0], cur};

  // windows 0..3 lie inside cur; 4..7 straddle prev/cur
  always_comb begin
    in_cnt = '0;
    cs_cnt = '0;
    for (int k = 0; k < 4; k++)
      in_cnt = in_cnt + 3'(win[k +: 5] == pat);
    for (int j = 0; j < 8; j++)
      cs_cnt = cs_cnt + 4'(win[j +: 5] == pat);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.ack       = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) nxt = LDPAT;
      end
      LDPAT: begin
        bus.busy     = 1'b1;
        bus.mem_addr = PAT_A;
        nxt          = SCAN;
      end
      SCAN: begin
        bus.busy     = 1'b1;
        bus.mem_addr = idx;
        if (idx == LAST) nxt = WR_CTB;
      end
      WR_CTB: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = RES_A;
        bus.mem_wdata = ctb;
        nxt           = WR_CTO;
      end
      WR_CTO: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = RES_A + AW'(1);
        bus.mem_wdata = cto;
        nxt           = WR_CTS;
      end
      WR_CTS: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = RES_A + AW'(2);
        bus.mem_wdata = cts;
        nxt           = DONE;
      end
      DONE: begin
        bus.ack = 1'b1;
        if (bus.start) nxt = LDPAT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      pat  <= '0;
      prev <= '0;
      ctb  <= '0;
      cto  <= '0;
      cts  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            idx  <= '0;
            prev <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
          end
        end
        LDPAT: begin
          pat <= bus.mem_rdata[7:3];
          idx <= '0;
        end
        SCAN: begin
          ctb  <= ctb + {5'b0, in_cnt};
          cto  <= cto + {7'b0, in_cnt != 3'd0};
          if (idx == '0) cts <= cts + {5'b0, in_cnt};
          else           cts <= cts + {4'b0, cs_cnt};
          prev <= cur;
          idx  <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl with a
// bit-string reference model and a memory model.
module tb_pattern_scan_ctrl;

  localparam int NB  = 32;
  localparam int PA  = 32;
  localparam int RA  = 33;
  localparam int LAT = NB + 4;

  typedef struct {
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] mem [0:255];

  pattern_scan_ctrl_if #(.AW(8)) bus ();

  pattern_scan_ctrl #(
    .NUM_BYTES(NB),
    .PAT_ADDR (PA),
    .RES_ADDR (RA),
    .AW       (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   we_cnt   = 0;
  logic ack_q    = 1'b0;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, req);
    end
  endtask

  // Counts taken over the message as one MSB-first
  // bit string: every 5-bit window that matches.
  function automatic exp_t ref_model();
    exp_t       e;
    logic [4:0] p;
    logic       bits [0:NB*8-1];
    logic       hit  [0:NB-1];
    int         nb, no, ns;
    bit         m;
    p  = mem[PA][7:3];
    nb = 0;
    no = 0;
    ns = 0;
    for (int b = 0; b < NB; b++) begin
      hit[b] = 1'b0;
      for (int i = 0; i < 8; i++)
        bits[8*b+i] = mem[b][7-i];
    end
    for (int s = 0; s <= NB*8-5; s++) begin
      m = 1'b1;
      for (int t = 0; t < 5; t++)
        if (bits[s+t] != p[4-t]) m = 1'b0;
      if (m) begin
        ns++;
        if ((s % 8) <= 3) begin
          nb++;
          hit[s/8] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NB; b++)
      if (hit[b]) no++;
    e.ctb = 8'(nb);
    e.cto = 8'(no);
    e.cts = 8'(ns);
    e.t   = 0;
    return e;
  endfunction

  task automatic fill(input logic [7:0] p,
                      input logic [7:0] v);
    mem[PA] = p;
    for (int b = 0; b < NB; b++) mem[b] = v;
  endtask

  task automatic fill_rand();
    mem[PA] = 8'($urandom);
    for (int b = 0; b < NB; b++)
      mem[b] = ($urandom_range(0, 3) == 0) ?
               8'h00 : 8'($urandom);
  endtask

  // Enqueue the model answer, then raise start.
  task automatic issue(input int hold);
    exp_t e;
    @(negedge clk);
    e   = ref_model();
    e.t = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1;
    repeat (hold) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got 0 expected 1");
    end
  endtask

  task automatic run(input int hold);
    int d0;
    d0 = done_cnt;
    issue(hold);
    wait_done(d0);
  endtask

  initial begin
    exp_t e;
    int   d0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    bus.start = 1'b0;
    reset     = 1'b1;

    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      end
      forever begin
        @(negedge clk);
        if (reset) we_cnt = 0;
        if (bus.mem_we) begin
          chk("we_addr", int'(bus.mem_addr), RA + we_cnt);
          we_cnt++;
        end
        if (bus.ack && !ack_q) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack: got 1 expected 0");
          end else begin
            e = sb.pop_front();
            chk("res_ctb", int'(mem[RA]),   int'(e.ctb));
            chk("res_cto", int'(mem[RA+1]), int'(e.cto));
            chk("res_cts", int'(mem[RA+2]), int'(e.cts));
            chk("latency", cyc - e.t, LAT);
            chk("we_count", we_cnt, 3);
          end
          we_cnt = 0;
          done_cnt++;
        end
        ack_q = bus.ack;
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ack",  int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_we",   int'(bus.mem_we), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_wd",   int'(bus.mem_wdata), 0);
    reset = 1'b0;
    @(negedge clk);

    fill(8'h00, 8'h00);
    run(1);
    fill(8'hA8, 8'h55);
    run(1);
    fill(8'h00, 8'hFF);
    run(1);
    fill(8'h70, 8'h00);
    mem[0] = 8'h03;
    mem[1] = 8'h80;
    run(1);

    // abort mid-scan; results must remain untouched
    fill(8'h00, 8'h00);
    mem[RA]   = 8'hEE;
    mem[RA+1] = 8'hEE;
    mem[RA+2] = 8'hEE;
    issue(1);
    repeat (11) @(negedge clk);
    chk("pre_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    void'(sb.pop_back());
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ack",  int'(bus.ack), 0);
    chk("abort_we",   int'(bus.mem_we), 0);
    chk("abort_addr", int'(bus.mem_addr), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_r0", int'(mem[RA]),   8'hEE);
    chk("abort_r1", int'(mem[RA+1]), 8'hEE);
    chk("abort_r2", int'(mem[RA+2]), 8'hEE);
    fill(8'hA8, 8'h55);
    run(1);

    // start held through the scan, restart from DONE
    fill_rand();
    run(20);
    fill_rand();
    d0 = done_cnt;
    issue(1);
    chk("restart_ack",  int'(bus.ack), 0);
    chk("restart_busy", int'(bus.busy), 1);
    wait_done(d0);

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      run(1);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
